// File: rtl/fixed_multiplier_seq.sv
// Sequential signed fixed-point multiplier: radix-2 shift-add over operand magnitudes,
// one partial product per clock, truncated toward zero and saturated with an overflow flag.
module fixed_multiplier_seq #(
   parameter int WIDTH     = 32,
   parameter int FRAC_BITS = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic             overflow
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]      LAST_BIT = CW'(WIDTH - 1);
   localparam logic [CW-1:0]      COUNT_ONE = CW'(1);
   localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
   localparam logic [2*WIDTH-1:0] POS_MAX  = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic [2*WIDTH-1:0] NEG_MAX  = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t             state;
   logic               sign;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      count;

   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [2*WIDTH-1:0] mag;
   logic [WIDTH-1:0]   sat_product;
   logic               sat_overflow;

   // Magnitudes stay unsigned, so the most negative operand maps cleanly to 2^(WIDTH-1).
   assign abs_a = a[WIDTH-1] ? (~a + ONE_W) : a;
   assign abs_b = b[WIDTH-1] ? (~b + ONE_W) : b;
   assign mag   = acc >> FRAC_BITS;

   always_comb begin
      sat_product  = '0;
      sat_overflow = 1'b0;
      if (!sign) begin
         if (mag > POS_MAX) begin
            sat_product  = {1'b0, {(WIDTH-1){1'b1}}};
            sat_overflow = 1'b1;
         end else begin
            sat_product = mag[WIDTH-1:0];
         end
      end else begin
         // Negation of a zero magnitude yields zero, so no negative zero can appear.
         if (mag > NEG_MAX) begin
            sat_product  = {1'b1, {(WIDTH-1){1'b0}}};
            sat_overflow = 1'b1;
         end else begin
            sat_product = ~mag[WIDTH-1:0] + ONE_W;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sign     <= 1'b0;
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         count    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         product  <= '0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  sign   <= a[WIDTH-1] ^ b[WIDTH-1];
                  mcand  <= {{WIDTH{1'b0}}, abs_a};
                  mplier <= abs_b;
                  acc    <= '0;
                  count  <= '0;
                  busy   <= 1'b1;
                  state  <= CALC;
               end
            end
            CALC: begin
               // The multiplicand shifts left as the multiplier shifts right, so bit 0 is always the current bit.
               if (mplier[0]) begin
                  acc <= acc + mcand;
               end
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + COUNT_ONE;
               if (count == LAST_BIT) begin
                  state <= FINISH;
               end
            end
            FINISH: begin
               product  <= sat_product;
               overflow <= sat_overflow;
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fixed_multiplier_seq.sv
// Self-checking bench for fixed_multiplier_seq: directed vector table, randomized operands
// against a longint reference model, and handshake/reset corner sequences.
`timescale 1ns/1ps
module tb_fixed_multiplier_seq;
   localparam int WIDTH     = 32;
   localparam int FRAC_BITS = 14;
   localparam int LATENCY   = WIDTH + 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic              busy;
   logic              done;
   logic [WIDTH-1:0]  product;
   logic              overflow;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_p;
      logic        exp_ov;
      string       name;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   fixed_multiplier_seq #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .product  (product),
      .overflow (overflow)
   );

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: exact signed product, C-style division truncates toward zero, then clamp.
   function automatic logic [32:0] refMul(input logic [31:0] x, input logic [31:0] y);
      longint p;
      longint q;
      longint scale;
      scale = longint'(1) << FRAC_BITS;
      p = longint'($signed(x)) * longint'($signed(y));
      q = p / scale;
      if (q > 64'sd2147483647)  return {1'b1, 32'h7FFFFFFF};
      if (q < -64'sd2147483648) return {1'b1, 32'h80000000};
      return {1'b0, q[31:0]};
   endfunction

   task automatic applyStimulus(input logic [31:0] ai, input logic [31:0] bi);
      a     = ai;
      b     = bi;
      start = 1'b1;
   endtask

   // Called on a negedge just before the accepting edge; counts negedges until done is seen.
   task automatic waitDone(input bit drop_start, input int inject_at,
                           output int lat, output int busy_n, output bit stable);
      logic [31:0] p0;
      logic        ov0;
      int          n;
      p0 = product;
      ov0 = overflow;
      n = 0;
      busy_n = 0;
      stable = 1'b1;
      lat = -1;
      forever begin
         @(negedge clk);
         n++;
         if (drop_start && n == 1) start = 1'b0;
         if (inject_at != 0 && n == inject_at) begin
            start = 1'b1;
            a = $urandom;
            b = $urandom;
         end
         if (inject_at != 0 && n == inject_at + 1) start = 1'b0;
         if (busy) busy_n++;
         if (done) begin
            lat = n - 1;
            break;
         end
         if (product !== p0 || overflow !== ov0) stable = 1'b0;
         if (n >= 3 * LATENCY) begin
            $display("[TB] FAIL %s: got no done, expected done within %0d clocks", "timeout", 3 * LATENCY);
            break;
         end
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] exp_p, input logic exp_ov,
                              input int lat, input int busy_n, input bit stable);
      checkVal({name, " latency"},  64'(lat),    64'(LATENCY));
      checkVal({name, " busy"},     64'(busy_n), 64'(LATENCY));
      checkVal({name, " stable"},   64'(stable), 64'd1);
      checkVal({name, " product"},  64'(product), 64'(exp_p));
      checkVal({name, " overflow"}, 64'(overflow), 64'(exp_ov));
   endtask

   task automatic runOp(input vec_t v, input int inject_at);
      int lat;
      int busy_n;
      bit stable;
      applyStimulus(v.a, v.b);
      waitDone(1'b1, inject_at, lat, busy_n, stable);
      checkOutput(v.name, v.exp_p, v.exp_ov, lat, busy_n, stable);
      @(negedge clk);
      checkVal({v.name, " pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before 2 ms");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          lat;
      int          busy_n;
      bit          stable;
      bit          saw_done;
      logic [31:0] x;
      logic [31:0] y;
      logic [32:0] r;

      vecs.push_back('{32'h00006000, 32'h00008000, 32'h0000C000, 1'b0, "1.5x2"});
      vecs.push_back('{32'hFFFFA000, 32'h00008000, 32'hFFFF4000, 1'b0, "-1.5x2"});
      vecs.push_back('{32'hFFFFA000, 32'hFFFF8000, 32'h0000C000, 1'b0, "-1.5x-2"});
      vecs.push_back('{32'h00002001, 32'h00002000, 32'h00001000, 1'b0, "trunc_pos"});
      vecs.push_back('{32'hFFFFDFFF, 32'h00002000, 32'hFFFFF000, 1'b0, "trunc_neg"});
      vecs.push_back('{32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, "tiny_neg_zero"});
      vecs.push_back('{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, "sat_pos"});
      vecs.push_back('{32'h80000000, 32'h00004000, 32'h80000000, 1'b0, "min_x1"});
      vecs.push_back('{32'h80000000, 32'h00008000, 32'h80000000, 1'b1, "sat_neg"});
      vecs.push_back('{32'h80000000, 32'h80000000, 32'h7FFFFFFF, 1'b1, "min_x_min"});
      vecs.push_back('{32'h00000000, 32'h12345678, 32'h00000000, 1'b0, "zero_a"});
      vecs.push_back('{32'h87654321, 32'h00000000, 32'h00000000, 1'b0, "zero_b"});
      vecs.push_back('{32'h7FFFFFFF, 32'hFFFFC000, 32'h80000001, 1'b0, "max_x_neg1"});

      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clk);
      checkVal("reset busy",     64'(busy),     64'd0);
      checkVal("reset done",     64'(done),     64'd0);
      checkVal("reset product",  64'(product),  64'd0);
      checkVal("reset overflow", 64'(overflow), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         runOp(vecs[i], 0);
      end

      for (int i = 0; i < 25; i++) begin
         x = $urandom;
         y = $urandom;
         x = 32'($signed(x) >>> $urandom_range(4, 24));
         y = 32'($signed(y) >>> $urandom_range(4, 24));
         r = refMul(x, y);
         runOp('{x, y, r[31:0], r[32], $sformatf("rand%0d", i)}, 0);
      end

      // A start pulse with fresh operands mid-CALC must not disturb the running operation.
      runOp('{32'h00006000, 32'hFFFF8000, 32'hFFFF4000, 1'b0, "ignore_midcalc"}, 10);

      // Start held through done: the second operation begins at the edge after the done cycle.
      applyStimulus(32'h00006000, 32'h00008000);
      waitDone(1'b0, 0, lat, busy_n, stable);
      checkOutput("held_first", 32'h0000C000, 1'b0, lat, busy_n, stable);
      a = 32'h00002001;
      b = 32'h00002000;
      waitDone(1'b1, 0, lat, busy_n, stable);
      checkOutput("held_second", 32'h00001000, 1'b0, lat, busy_n, stable);
      @(negedge clk);
      checkVal("held_second pulse", 64'(done), 64'd0);

      applyStimulus(32'hFFFFA000, 32'h00008000);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkVal("midreset busy",     64'(busy),     64'd0);
      checkVal("midreset done",     64'(done),     64'd0);
      checkVal("midreset product",  64'(product),  64'd0);
      checkVal("midreset overflow", 64'(overflow), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 2 * LATENCY; i++) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      checkVal("midreset no_done", 64'(saw_done), 64'd0);
      runOp('{32'hFFFFA000, 32'h00008000, 32'hFFFF4000, 1'b0, "after_reset"}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
